pipe_cska_adder: RTL and testbench
==================================

PIPE_CSKA_ADDER -- requirements
Module: pipe_cska_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of BLK.
REQ-002 Parameter BLK, default 4, carry-skip block size in bits.
REQ-003 Parameter STAGES, default 2, pipeline depth; (WIDTH/BLK) SHALL be a multiple of STAGES.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand set on a/b/c/sub is valid.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-010 b  input  WIDTH  operand B.
REQ-011 c  input  1  carry-in (add) / borrow-in (sub).
REQ-012 sub  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  s/ovf hold a valid result.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 s  output  WIDTH+1  result; s[WIDTH] = carry-out.
REQ-016 ovf  output  1  signed two's-complement overflow of s[WIDTH-1:0].

Function
REQ-017 Transfer in SHALL occur on a rising clk edge where in_valid && in_ready; transfer out where out_valid && out_ready.
REQ-018 Add (sub=0): s SHALL equal a + b + c, zero-extended to WIDTH+1 bits.
REQ-019 Subtract (sub=1): s SHALL equal a + ~b + !c (WIDTH+1 bits), i.e. a - b - c; s[WIDTH]=1 means no borrow.
REQ-020 ovf SHALL be 1 iff the effective operands a and (sub ? ~b : b) share an MSB and s[WIDTH-1] differs from it.
REQ-021 Carry SHALL be resolved per BLK-bit block: block propagate P = AND of (a ^ b_eff) over the block; block carry-out = P ? block carry-in : ripple carry-out.
REQ-022 Blocks SHALL be split evenly across STAGES; stage k computes blocks k*(WIDTH/BLK/STAGES) through (k+1)*(WIDTH/BLK/STAGES)-1, registering the inter-stage carry, the completed low sum bits and the not-yet-processed high operand bits.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-024 Throughput SHALL be one operation per cycle when out_ready=1 continuously.
REQ-025 Each stage SHALL hold a valid flag; a stage SHALL load when it is empty or its contents move on in the same cycle.
REQ-026 in_ready SHALL be 1 iff stage 0 is empty or stage 0 advances this cycle (combinational from out_ready through the chain; no combinational path from in_valid).
REQ-027 While out_valid=1 and out_ready=0, s, ovf and out_valid SHALL remain stable; bubbles in earlier stages SHALL be collapsed (stages fill up behind the stall).
REQ-028 With all STAGES full and out_ready=0, in_ready SHALL be 0 and no operand SHALL be lost or duplicated.
REQ-029 Simultaneous input and output transfer with a full pipeline SHALL be accepted in the same cycle.
REQ-030 Results SHALL emerge in acceptance order.
REQ-031 out_valid SHALL be registered; s and ovf SHALL be driven directly from the final stage registers.

Reset
REQ-032 rst_n=0 SHALL immediately clear all stage valid flags and data registers: out_valid=0, s=0, ovf=0.
REQ-033 in_ready SHALL be 0 while rst_n=0 and 1 on the first clock after deassertion.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations; no result from them SHALL appear after reset.

Verification (WIDTH=16, BLK=4, STAGES=2 unless noted)
REQ-035 a=FFFF, b=0001, c=0, sub=0, out_ready=1 -> 2 cycles later s=10000, ovf=0.
REQ-036 Back-to-back a=1234/b=5678/c=1, a=ABCD/b=4321/c=0, a=FFFF/b=FFFF/c=1 -> s=068AD, 0EEEE, 1FFFF on consecutive cycles, ovf=0,0,0.
REQ-037 sub=1, a=0000, b=0001, c=0 -> s=0FFFF, ovf=0; sub=1, a=8000, b=0001, c=0 -> s=17FFF, ovf=1.
REQ-038 Hold out_ready=0 for 5 cycles while driving 4 operands -> 2 accepted, in_ready=0 afterwards, s stable; release -> both results in order, no loss.
REQ-039 Pull rst_n low with 2 operations in flight -> out_valid=0, s=0 immediately; no stale result after release.
REQ-040 Randomised run at WIDTH=32/BLK=4/STAGES=4 and WIDTH=64/BLK=8/STAGES=2 with random out_ready -> every result matches a+b+c / a-b-c reference model, in order.

Source files
------------

// File: rtl/pipe_cska_adder.sv
// pipe_cska_adder: pipelined carry-skip adder/subtractor with valid/ready flow control.
// Each stage resolves WIDTH/STAGES bits and passes the carry and remaining operand bits forward.
module pipe_cska_adder #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic [STAGES-1:0] v_q, v_d, adv, ld;
  logic [STAGES:0]   rdy;
  logic              ovf_q, ovf_d;
  // Ready ripples back from the output so a full pipe can accept while it drains.
  always_comb begin
    rdy = '0;
    adv = '0;
    ld = '0;
    rdy[STAGES] = out_ready;
    for (int k = L; k >= 0; k--) begin
      adv[k] = v_q[k] & rdy[k+1];
      rdy[k] = ~v_q[k] | adv[k];
    end
    ld[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) ld[k] = adv[k-1];
    v_d = ld | (v_q & ~adv);
  end
  assign in_ready = rst_n & rdy[0];
  for (genvar g = 0; g < STAGES; g++) begin : st
    localparam int R = WIDTH - g * SW;
    logic [R-1:0]          ah, bh;
    logic [SW-1:0]         sc;
    logic [(g+1)*SW-1:0]   s_d, s_q;
    logic                  ci, c_d, c_q, rc, pb;
    if (g == 0) begin : src
      assign ah  = a;
      assign bh  = sub ? ~b : b;
      assign ci  = sub ? ~c : c;
      assign s_d = sc;
    end else begin : src
      assign ah  = st[g-1].nx.ah_q;
      assign bh  = st[g-1].nx.bh_q;
      assign ci  = st[g-1].c_q;
      assign s_d = {sc, st[g-1].s_q};
    end
    always_comb begin
      c_d = ci;
      sc = '0;
      rc = 1'b0;
      pb = 1'b0;
      for (int j = 0; j < SW; j += BLK) begin
        rc = c_d;
        pb = 1'b1;
        for (int i = j; i < j + BLK; i++) begin
          sc[i] = ah[i] ^ bh[i] ^ rc;
          rc = (ah[i] & bh[i]) | ((ah[i] ^ bh[i]) & rc);
          pb = pb & (ah[i] ^ bh[i]);
        end
        c_d = pb ? c_d : rc;
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ld[g]) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    if (g < L) begin : nx
      logic [R-SW-1:0] ah_q, bh_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ah_q <= '0;
          bh_q <= '0;
        end else if (ld[g]) begin
          ah_q <= ah[R-1:SW];
          bh_q <= bh[R-1:SW];
        end
    end
  end
  assign ovf_d = (st[L].ah[SW-1] == st[L].bh[SW-1]) & (st[L].sc[SW-1] != st[L].ah[SW-1]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q <= v_d;
      if (ld[L]) ovf_q <= ovf_d;
    end
  assign out_valid = v_q[L];
  assign s         = {st[L].c_q, st[L].s_q};
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_cska_adder.sv
// tb_pipe_cska_adder: directed checks of the pipelined carry-skip adder (16-bit, 4-bit blocks, 2 stages).
module tb_pipe_cska_adder;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, c = 0, sub = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, ovf;
  logic [W:0] s;
  int n_tot = 0, n_bad = 0, cyc = 0, k = 0, t_v = 0;
  bit lat_en = 0, done = 0;
  logic [W+1:0] exp_q[$], e_v;
  int acc_q[$];
  logic [W-1:0] va[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [W-1:0] vb[4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
  logic [W:0]   ve[4] = '{17'h01212, 17'h02424, 17'h03636, 17'h04848};

  pipe_cska_adder #(.WIDTH(W), .BLK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (out_valid && out_ready) begin
    if (exp_q.size() == 0) chk("stray", out_valid, 0);
    else begin
      e_v = exp_q.pop_front();
      t_v = acc_q.pop_front();
      chk("sum", s, e_v[W:0]);
      chk("ovf", ovf, e_v[W+1]);
      if (lat_en) chk("lat", cyc - t_v, 2);
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                      input logic [W:0] es, input logic eo);
    a = ta; b = tb; c = tc; sub = ts; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({eo, es});
        acc_q.push_back(cyc);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", in_ready, 1);
  endtask

  function automatic logic [W+1:0] mdl(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    logic [W-1:0] be;
    logic [W:0] sm;
    be = ts ? ~tb : tb;
    sm = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ts ? ~tc : tc};
    return {(ta[W-1] == be[W-1]) && (sm[W-1] != ta[W-1]), sm};
  endfunction

  task automatic send_m(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    logic [W+1:0] r;
    r = mdl(ta, tb, tc, ts);
    send(ta, tb, tc, ts, r[W:0], r[W+1]);
  endtask

  initial begin
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ir", in_ready, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("ir_after_rst", in_ready, 1);
    out_ready = 1; lat_en = 1;
    send(16'hFFFF, 16'h0001, 0, 0, 17'h10000, 0);
    send(16'h1234, 16'h5678, 1, 0, 17'h068AD, 0);
    send(16'hABCD, 16'h4321, 0, 0, 17'h0EEEE, 0);
    send(16'hFFFF, 16'hFFFF, 1, 0, 17'h1FFFF, 0);
    send(16'h0000, 16'h0001, 0, 1, 17'h0FFFF, 0);
    send(16'h8000, 16'h0001, 0, 1, 17'h17FFF, 1);
    send(16'h7FFF, 16'h0001, 0, 0, 17'h08000, 1);
    send(16'h8000, 16'h8000, 0, 0, 17'h10000, 1);
    send(16'h0005, 16'h0003, 1, 1, 17'h10001, 0);
    send(16'h00FF, 16'h0001, 0, 0, 17'h00100, 0);
    send(16'h0FFF, 16'h0000, 1, 0, 17'h01000, 0);
    in_valid = 0; lat_en = 0;
    repeat (4) @(posedge clk); #1;
    chk("drain1", exp_q.size(), 0);
    out_ready = 0; in_valid = 1; c = 0; sub = 0; k = 0;
    for (int i = 0; i < 5; i++) begin
      if (k < 4) begin a = va[k]; b = vb[k]; end
      @(negedge clk);
      if (out_valid) chk("hold_s", s, ve[0]);
      if (in_ready && k < 4) begin
        exp_q.push_back({1'b0, ve[k]});
        acc_q.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
    end
    chk("stall_acc", k, 2);
    @(negedge clk);
    chk("stall_ir", in_ready, 0);
    chk("stall_ov", out_valid, 1);
    chk("stall_s", s, ve[0]);
    @(posedge clk); #1;
    a = va[2]; b = vb[2]; out_ready = 1;
    @(negedge clk);
    chk("full_ir", in_ready, 1);
    exp_q.push_back({1'b0, ve[2]});
    acc_q.push_back(cyc);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk); #1;
    chk("drain2", exp_q.size(), 0);
    send_m(16'h1111, 16'h2222, 0, 0);
    send_m(16'h3333, 16'h4444, 1, 1);
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("mid_ov", out_valid, 0);
    chk("mid_s", s, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_ir", in_ready, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ir_after_mid", in_ready, 1);
    repeat (4) @(posedge clk); #1;
    chk("no_stale", out_valid, 0);
    fork
      begin
        for (int i = 0; i < 40; i++) send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1;
    repeat (6) @(posedge clk); #1;
    chk("drain3", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
